// File: rtl/led_pattern_ctrl_if.sv
// External requester handshake for the LED bank: request level, requested pattern
// and the registered grant returned by the controller.
interface led_pattern_ctrl_if #(
    parameter int unsigned LED_W = 6
);
    logic             ext_req;
    logic [LED_W-1:0] ext_led;
    logic             ext_gnt;

    modport master (
        output ext_req,
        output ext_led,
        input  ext_gnt
    );

    modport slave (
        input  ext_req,
        input  ext_led,
        output ext_gnt
    );
endinterface

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: four tick-driven patterns selected by a debounced push button,
// with an external requester able to take over the LEDs while pattern state freezes.
module led_pattern_ctrl #(
    parameter int unsigned LED_W        = 6,
    parameter int unsigned TICK_DIV     = 5_000_000,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic              clk_50m,
    input  logic              reset_n,
    input  logic              key_n,
    led_pattern_ctrl_if.slave ext,
    output logic [1:0]        mode,
    output logic [LED_W-1:0]  led
);

    localparam int unsigned TW  = $clog2(TICK_DIV);
    localparam int unsigned DBW = $clog2(DEBOUNCE_CYC);
    localparam logic [TW-1:0]  TickLast = TW'(TICK_DIV - 1);
    localparam logic [DBW-1:0] DbLast   = DBW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        ModeShift  = 2'd0,
        ModeBounce = 2'd1,
        ModeBlink  = 2'd2,
        ModeCount  = 2'd3
    } mode_e;

    logic             r_key_meta;
    logic             r_key_sync;
    logic             r_key_db;
    logic [DBW-1:0]   r_db_cnt;
    logic [TW-1:0]    r_tick_cnt;
    logic [LED_W-1:0] r_pat;
    logic             r_dir_left;
    mode_e            r_mode;
    logic             r_ext_gnt;
    logic [LED_W-1:0] r_led;

    logic             w_db_accept;
    logic             w_press;
    logic             w_tick;
    mode_e            w_mode_next;
    logic [LED_W-1:0] w_init_pat;
    logic [LED_W-1:0] w_step_pat;
    logic             w_step_dir_left;

    // Key synchronizer and debounce; the debounced level starts released.
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            r_key_meta <= 1'b1;
            r_key_sync <= 1'b1;
            r_key_db   <= 1'b1;
            r_db_cnt   <= '0;
        end else begin
            r_key_meta <= key_n;
            r_key_sync <= r_key_meta;
            if (r_key_sync == r_key_db) begin
                r_db_cnt <= '0;
            end else if (w_db_accept) begin
                r_key_db <= r_key_sync;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DBW'(1);
            end
        end
    end

    assign w_db_accept = (r_key_sync != r_key_db) && (r_db_cnt == DbLast);
    assign w_press     = w_db_accept && !r_key_sync;
    assign w_tick      = !r_ext_gnt && (r_tick_cnt == TickLast);
    assign w_mode_next = mode_e'(r_mode + 2'd1);

    always_comb begin
        w_init_pat = '0;
        if (w_mode_next == ModeShift || w_mode_next == ModeBounce) begin
            w_init_pat = LED_W'(1);
        end
    end

    always_comb begin
        w_step_pat      = r_pat;
        w_step_dir_left = r_dir_left;
        unique case (r_mode)
            ModeShift:  w_step_pat = {r_pat[LED_W-2:0], r_pat[LED_W-1]};
            ModeBounce: begin
                if (r_dir_left) begin
                    w_step_pat      = r_pat << 1;
                    w_step_dir_left = !w_step_pat[LED_W-1];
                end else begin
                    w_step_pat      = r_pat >> 1;
                    w_step_dir_left = w_step_pat[0];
                end
            end
            ModeBlink:  w_step_pat = ~r_pat;
            ModeCount:  w_step_pat = r_pat + LED_W'(1);
            default:    w_step_pat = r_pat;
        endcase
    end

    // A press overrides a coincident tick and is honoured even while granted.
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            r_mode     <= ModeShift;
            r_pat      <= LED_W'(1);
            r_dir_left <= 1'b1;
            r_tick_cnt <= '0;
        end else if (w_press) begin
            r_mode     <= w_mode_next;
            r_pat      <= w_init_pat;
            r_dir_left <= 1'b1;
            r_tick_cnt <= '0;
        end else if (!r_ext_gnt) begin
            if (w_tick) begin
                r_tick_cnt <= '0;
                r_pat      <= w_step_pat;
                r_dir_left <= w_step_dir_left;
            end else begin
                r_tick_cnt <= r_tick_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            r_ext_gnt <= 1'b0;
            r_led     <= '0;
        end else begin
            r_ext_gnt <= ext.ext_req;
            r_led     <= r_ext_gnt ? ext.ext_led : r_pat;
        end
    end

    assign ext.ext_gnt = r_ext_gnt;
    assign mode        = r_mode;
    assign led         = r_led;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Randomized bench for led_pattern_ctrl with a step-count reference model and a
// per-cycle compare, plus literal checks at the directed scenario points.
module tb_led_pattern_ctrl;

    localparam int LW  = 6;
    localparam int TD  = 4;
    localparam int DEB = 8;

    logic          clk_50m = 1'b0;
    logic          reset_n = 1'b0;
    logic          key_n   = 1'b1;
    logic [1:0]    mode;
    logic [LW-1:0] led;

    int errors = 0;
    int checks = 0;

    led_pattern_ctrl_if #(.LED_W(LW)) ext_if ();

    led_pattern_ctrl #(
        .LED_W        (LW),
        .TICK_DIV     (TD),
        .DEBOUNCE_CYC (DEB)
    ) dut (
        .clk_50m (clk_50m),
        .reset_n (reset_n),
        .key_n   (key_n),
        .ext     (ext_if),
        .mode    (mode),
        .led     (led)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Pattern after k ticks since the mode was entered.
    function automatic logic [LW-1:0] pat(input int md, input int k);
        int p;
        case (md)
            0: return LW'(1 << (k % LW));
            1: begin
                p = k % (2 * (LW - 1));
                if (p > LW - 1) p = 2 * (LW - 1) - p;
                return LW'(1 << p);
            end
            2: return (k % 2 == 1) ? {LW{1'b1}} : '0;
            default: return LW'(k % (1 << LW));
        endcase
    endfunction

    // Model state: key pipeline, debounced level/run, mode, ticks taken, tick phase.
    int            m_s1, m_s2, m_db, m_run, m_mode, m_k, m_ph, m_gnt;
    logic [LW-1:0] m_led;

    task automatic m_reset();
        m_s1 = 1; m_s2 = 1; m_db = 1; m_run = 0;
        m_mode = 0; m_k = 0; m_ph = 0; m_gnt = 0; m_led = '0;
    endtask

    task automatic m_step();
        bit            press;
        logic [LW-1:0] nled;
        press = (m_s2 != m_db) && (m_run == DEB - 1) && (m_s2 == 0);
        if (m_s2 == m_db) m_run = 0;
        else if (m_run == DEB - 1) begin m_db = m_s2; m_run = 0; end
        else m_run++;
        nled = (m_gnt != 0) ? ext_if.ext_led : pat(m_mode, m_k);
        if (press) begin
            m_mode = (m_mode + 1) % 4; m_k = 0; m_ph = 0;
        end else if (m_gnt == 0) begin
            if (m_ph == TD - 1) begin m_ph = 0; m_k++; end
            else m_ph++;
        end
        m_gnt = int'(ext_if.ext_req);
        m_led = nled;
        m_s2 = m_s1;
        m_s1 = int'(key_n);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk_50m or negedge reset_n);
            if (!reset_n) m_reset();
            else m_step();
            #1;
            chk("led", int'(led), int'(m_led));
            chk("gnt", int'(ext_if.ext_gnt), m_gnt);
            chk("mode", int'(mode), m_mode);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic press_key(input int low, input int high);
        key_n = 1'b0; cycles(low);
        key_n = 1'b1; cycles(high);
    endtask

    task automatic pulse_reset();
        @(negedge clk_50m);
        reset_n = 1'b0;
        #1;
        chk("rst_led", int'(led), 0);
        chk("rst_gnt", int'(ext_if.ext_gnt), 0);
        chk("rst_mode", int'(mode), 0);
        cycles(2);
        reset_n = 1'b1;
    endtask

    initial begin
        int r, n;
        ext_if.ext_req = 1'b0;
        ext_if.ext_led = '0;
        cycles(3);
        reset_n = 1'b1;
        @(posedge clk_50m); #1;
        chk("shift_first", int'(led), 1);
        repeat (4) @(posedge clk_50m);
        #1;
        chk("shift_second", int'(led), 2);
        cycles(40);

        press_key(20, 20);
        chk("press_mode", int'(mode), 1);
        press_key(5, 20);
        chk("glitch_mode", int'(mode), 1);
        cycles(30);

        ext_if.ext_led = 6'b101010;
        ext_if.ext_req = 1'b1;
        @(posedge clk_50m); #1;
        chk("gnt_rise", int'(ext_if.ext_gnt), 1);
        @(posedge clk_50m); #1;
        chk("gnt_led", int'(led), 6'b101010);
        cycles(28);
        ext_if.ext_req = 1'b0;
        @(posedge clk_50m); #1;
        chk("gnt_fall", int'(ext_if.ext_gnt), 0);
        cycles(20);

        ext_if.ext_req = 1'b1;
        press_key(20, 20);
        chk("grant_press_mode", int'(mode), 2);
        chk("grant_press_led", int'(led), 6'b101010);
        ext_if.ext_req = 1'b0;
        cycles(30);

        press_key(20, 20);
        chk("count_mode", int'(mode), 3);
        cycles(280);

        ext_if.ext_req = 1'b1;
        key_n = 1'b0;
        cycles(6);
        pulse_reset();
        cycles(5);
        key_n = 1'b1;
        ext_if.ext_req = 1'b0;
        cycles(30);

        for (int seg = 0; seg < 250; seg++) begin
            r = int'($urandom_range(0, 9));
            n = int'($urandom_range(1, 30));
            if (r <= 3) begin
                key_n = ~key_n;
                cycles(n);
            end else if (r <= 6) begin
                ext_if.ext_req = 1'($urandom_range(0, 1));
                ext_if.ext_led = LW'($urandom);
                cycles(n);
            end else if (r == 7) begin
                pulse_reset();
            end else begin
                cycles(n + 10);
            end
        end
        key_n = 1'b1;
        ext_if.ext_req = 1'b0;
        cycles(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Sequencer and arbiter for the 6-LED bank on the 50 MHz board clock.
- Generates four selectable animated patterns from an internal tick divider.
- A debounced push button cycles through the patterns.
- An external requester can take the LEDs through a req/gnt handshake. While it holds them, internal pattern state freezes and resumes when it releases.

Parameters:
- LED_W, 6, number of LED outputs.
- TICK_DIV, 5_000_000, clk_50m cycles per pattern step (100 ms at 50 MHz). Must be ≥2.
- DEBOUNCE_CYC, 1_000_000, cycles the synchronized key must be stable before a level change is accepted (20 ms). Must be ≥2.

Ports:
- clk_50m  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- key_n  in  1  raw push button, active-low, asynchronous to clk_50m.
- ext_req  in  1  external requester wants the LEDs. Level signal.
- ext_led  in  LED_W  pattern driven by the requester. Used only while ext_gnt=1.
- ext_gnt  out  1  LEDs owned by the external requester.
- mode  out  2  current pattern: 0 SHIFT, 1 BOUNCE, 2 BLINK, 3 COUNT.
- led  out  LED_W  registered LED drive, 1 = on.

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Reset values:
  - led=0, ext_gnt=0, mode=0.
  - Tick counter=0, pattern state=SHIFT initial (000001), direction=left.
  - Debounced key=1 (released); debounce counter=0.
- key_n path:
  - 2-flop synchronizer into a debounce counter.
  - Counter increments while the synchronized level differs from the debounced level; it clears when they agree.
  - At DEBOUNCE_CYC-1 the debounced level takes the new value and the counter clears.
  - A debounced 1→0 transition produces a one-cycle press pulse. Release must also be debounced before the next press counts.
- Press:
  - mode advances 0→1→2→3→0.
  - Pattern state loads the new mode's initial value; tick counter clears to 0.
  - The press is applied even while ext_gnt=1: mode output updates, led still shows ext_led.
- Tick:
  - Counter runs 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and a tick is issued that cycle.
  - A press in the same cycle wins: no step is taken, and the counter clears.
- Pattern step on tick:
  - SHIFT: initial 000001. Rotate left one bit; bit LED_W-1 wraps to bit 0.
  - BOUNCE: initial 000001, dir=left. Shift in dir; dir flips to right on reaching bit LED_W-1 and to left on reaching bit 0. Sequence 1,2,4,8,16,32,16,8,4,2,1,... (period 2*(LED_W-1) ticks).
  - BLINK: initial 000000. Bitwise invert each tick.
  - COUNT: initial 000000. Binary increment modulo 2^LED_W (111111→000000).
- Arbitration:
  - ext_gnt is a register: it follows ext_req one cycle later in both directions. There is no minimum hold time.
  - While ext_gnt=1: tick counter and pattern state hold (no steps are taken); presses are still honoured as above.
  - On release (ext_gnt 1→0), the tick counter resumes from its held value and the pattern resumes from its held state.
- led register:
  - Loads ext_led when ext_gnt=1; otherwise loads the pattern state.
  - Latency: pattern state change → led at +1 cycle. ext_req rise → ext_gnt at +1 → led=ext_led at +2.
  - ext_req fall → pattern visible at +2.
- Reset asserted mid-operation (mid-debounce, mid-grant, mid-tick) returns immediately to the reset values. Any grant is dropped.

Test Plan (TICK_DIV=4, DEBOUNCE_CYC=8):
1. Reset release, no inputs → led=000001 one cycle after release, then 000010, 000100 ... 100000, 000001 at 4-cycle spacing; mode=0.
2. key_n low for 20 cycles then high for 20 → exactly one press; mode=1, led=000001, then BOUNCE sequence 2,4,8,16,32,16,8 per tick. A 5-cycle glitch low → no mode change.
3. Four clean presses → mode 0→1→2→3→0 wraps. In BLINK, led alternates 000000/111111 per tick. In COUNT from 111110, two ticks → 111111 then 000000.
4. SHIFT at led=000100, ext_req=1 with ext_led=101010 for 30 cycles → ext_gnt=1 at +1, led=101010 at +2 and held. After ext_req=0 → gnt drops at +1, led=000100 at +2, then 001000 after the remaining tick count.
5. Press during grant → mode increments while led stays ext_led. After release, led shows the new mode's initial value.
6. reset_n pulsed low mid-grant and mid-debounce → led=0, ext_gnt=0, mode=0 immediately. Normal SHIFT restarts after release, even with ext_req still 1 (gnt returns at +1).
